pulse_play_ctrl: RTL and testbench
==================================

Name: pulse_play_ctrl

Overview:
Sequencer and port arbiter for the single-port 32-bit pulse waveform BRAM (8000 words, 1-cycle synchronous read). It shares the one BRAM port between a host loader, which writes waveform samples, and a playback engine, which streams a configured window of samples, optionally repeated, to the DAC path. It sits between the host register and loader logic and the BRAM. Its BRAM-side ports connect one-to-one to the BRAM enable, write-enable, address, data-in and data-out pins.

Parameters:
DATA_W, 32, sample and BRAM data width
ADDR_W, 32, BRAM address port width
DEPTH, 8000, number of valid BRAM words
IDX_W, 13, internal index width; must satisfy 2^IDX_W >= DEPTH
RPT_W, 16, repeat-count width

Ports:
clka  in  1  single clock; all logic is on the rising edge
rst_n  in  1  asynchronous, active-low reset
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted this cycle
wr_addr  in  ADDR_W  host write address
wr_data  in  DATA_W  host write data
wr_err  out  1  one-cycle pulse: the accepted write had an address >= DEPTH and was dropped
start  in  1  one-cycle playback start pulse
stop  in  1  abort playback
cfg_base  in  IDX_W  first sample index of the window
cfg_len  in  IDX_W  window length in samples
cfg_rpt  in  RPT_W  number of passes over the window
busy  out  1  high in PLAY and DRAIN
done  out  1  one-cycle pulse on return to IDLE after playback
out_valid  out  1  playback sample valid; there is no backpressure
out_data  out  DATA_W  playback sample
out_last  out  1  marks the final sample of the playback
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_W  BRAM address; upper bits are zero
bram_din  out  DATA_W  BRAM write data
bram_dout  in  DATA_W  BRAM read data, valid 1 cycle after a read

Behaviour:
- Reset: state IDLE. Outputs wr_ready, wr_err, busy, done, out_valid, out_last, bram_en and bram_we are 0. out_data, bram_addr and bram_din are 0. Reset applied mid-playback aborts immediately with no done pulse. BRAM contents are untouched.
- States: IDLE, PLAY, DRAIN.
- IDLE transitions:
  - start=1 and cfg_len!=0: latch base, len and rpt (0 is treated as 1). Set cur=base, pos=0, pass=1. Go to PLAY.
  - start=1 and cfg_len==0: ignored; stay in IDLE with no done pulse.
- Host write arbitration: wr_ready = (state==IDLE) && !start, combinational. A start in the same cycle wins, so the writer waits.
  - Write accepted with wr_addr < DEPTH: drive bram_en=1, bram_we=1, bram_addr=wr_addr, bram_din=wr_data in that same cycle.
  - Write accepted with wr_addr >= DEPTH: bram_en=0 and wr_err pulses on the next cycle.
- PLAY: issue one read every cycle: bram_en=1, bram_we=0, bram_addr=cur.
  - Read-issued flag registered, then output as out_valid with out_data=bram_dout. First sample appears 2 cycles after start; this is the fixed latency.
  - Index advance: cur = (cur+1==DEPTH) ? 0 : cur+1, so the window wraps modulo DEPTH.
  - End of a pass (pos==len-1): cur=base, pos=0, pass increments.
  - Last read issued (pos==len-1 and pass==rpt): go to DRAIN, tagging this read as last.
  - stop=1 in PLAY: no read that cycle; go to DRAIN. The already in-flight sample is output with out_last=1.
  - If nothing is in flight when stopping, out_last is not asserted.
- DRAIN: no BRAM access. The in-flight sample is output; then go to IDLE with done=1 for one cycle. stop in IDLE or DRAIN has no effect.
- Sample counts:
  - Total samples per playback = len*rpt, out_valid contiguous with no gaps.
  - out_last coincides with the final out_valid.
- Arithmetic: cur, pos and pass are unsigned; the pass counter is RPT_W bits wide.

Optional Feature:
PULSE_LOOP_EN
- Defined: cfg_rpt==0 means loop indefinitely; only stop ends playback, with the in-flight sample flagged out_last.
- Undefined: cfg_rpt==0 is treated as 1 pass.

Decomposition:
- Package pulse_play_pkg holds:
  - the state enum (IDLE, PLAY, DRAIN);
  - the DEPTH, IDX_W, DATA_W and RPT_W defaults;
  - a DEPTH-wrap increment function.
- One sub-module, pulse_addr_gen: the cur/pos/pass counters with a last-read flag. The FSM, arbitration and output pipeline stay in the top level.

Test Plan:
- Load words 0..9 with value i+100 via the write port, then start with base=0, len=4, rpt=2 -> out_data 100,101,102,103,100,101,102,103; first out_valid 2 cycles after start; out_last on the 8th sample; done 1 cycle later.
- base=7998, len=4, rpt=1 -> BRAM addresses 7998, 7999, 0, 1.
- start and wr_valid in the same IDLE cycle -> wr_ready=0 and playback begins; write accepted only after done.
- wr_addr=8000 -> wr_ready=1, bram_en=0, wr_err pulse next cycle.
- stop asserted on the 3rd PLAY cycle of len=10 -> exactly 2 samples out, the 2nd with out_last=1, then done.
- Reset asserted mid-PLAY -> busy, out_valid and bram_en drop to 0 asynchronously; no done; BRAM data unchanged on readback.

Source files
------------

// File: rtl/pulse_play_pkg.sv
// pulse_play_pkg: shared state type, default sizes and DEPTH-wrap index helper for pulse_play_ctrl
package pulse_play_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH  = 8000;
  localparam int DEF_IDX_W  = 13;
  localparam int DEF_RPT_W  = 16;
  typedef enum logic [1:0] {IDLE, PLAY, DRAIN} state_e;
  function automatic logic [31:0] wrap_inc(input logic [31:0] v, input int depth);
    return (v + 32'd1 == 32'(depth)) ? '0 : v + 32'd1;
  endfunction
endpackage

// File: rtl/pulse_addr_gen.sv
// pulse_addr_gen: playback index counters (cur/pos/pass) with last-read flag
// Ports: load_i latches the window config and restarts the counters, adv_i steps one read,
// cur_o is the BRAM index of the read issued this cycle, last_o marks that read as the final one.
// PULSE_LOOP_EN: when defined, cfg_rpt_i==0 never raises last_o (playback loops until stopped).
module pulse_addr_gen
  import pulse_play_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = DEF_IDX_W,
  parameter int RPT_W = DEF_RPT_W
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [IDX_W-1:0] cfg_base_i,
  input  logic [IDX_W-1:0] cfg_len_i,
  input  logic [RPT_W-1:0] cfg_rpt_i,
  output logic [IDX_W-1:0] cur_o,
  output logic             last_o
);
  logic [IDX_W-1:0] base_q, len_q, cur_q, cur_d, pos_q, pos_d;
  logic [RPT_W-1:0] rpt_q, pass_q, pass_d;
  logic end_pass;
  assign end_pass = pos_q == len_q - IDX_W'(1);
  assign cur_o = cur_q;
  always_comb begin
    cur_d  = load_i ? cfg_base_i : adv_i ? (end_pass ? base_q : IDX_W'(wrap_inc(32'(cur_q), DEPTH))) : cur_q;
    pos_d  = load_i ? '0 : adv_i ? (end_pass ? '0 : pos_q + IDX_W'(1)) : pos_q;
    pass_d = load_i ? RPT_W'(1) : (adv_i && end_pass) ? pass_q + RPT_W'(1) : pass_q;
  end
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      rpt_q  <= '0;
      cur_q  <= '0;
      pos_q  <= '0;
      pass_q <= '0;
    end else begin
      if (load_i) begin
        base_q <= cfg_base_i;
        len_q  <= cfg_len_i;
        rpt_q  <= (cfg_rpt_i == '0) ? RPT_W'(1) : cfg_rpt_i;
      end
      cur_q  <= cur_d;
      pos_q  <= pos_d;
      pass_q <= pass_d;
    end
`ifdef PULSE_LOOP_EN
  logic loop_q;
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) loop_q <= 1'b0;
    else if (load_i) loop_q <= cfg_rpt_i == '0;
  assign last_o = end_pass && (pass_q == rpt_q) && !loop_q;
`else
  assign last_o = end_pass && (pass_q == rpt_q);
`endif
endmodule

// File: rtl/pulse_play_ctrl.sv
// pulse_play_ctrl: single-port waveform BRAM arbiter between host writes and windowed playback
// Ports: wr_* host write channel (wr_err flags a dropped out-of-range write), start/stop and cfg_*
// control playback, busy/done status, out_* sample stream (fixed 2-cycle latency, no backpressure),
// bram_* connect straight to the BRAM pins (1-cycle synchronous read).
// PULSE_LOOP_EN: when defined, cfg_rpt==0 loops until stop.
module pulse_play_ctrl
  import pulse_play_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int RPT_W  = DEF_RPT_W
) (
  input  logic              clka,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              start,
  input  logic              stop,
  input  logic [IDX_W-1:0]  cfg_base,
  input  logic [IDX_W-1:0]  cfg_len,
  input  logic [RPT_W-1:0]  cfg_rpt,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);
  state_e state_q;
  logic vld_q, lst_q, done_q, wr_err_q;
  logic wr_acc, wr_ok, rd, load, last_rd;
  logic [IDX_W-1:0] cur;
  // rst_n gating keeps the host from seeing ready while reset is held
  assign wr_ready  = rst_n && state_q == IDLE && !start;
  assign wr_acc    = wr_valid && wr_ready;
  assign wr_ok     = wr_acc && wr_addr < ADDR_W'(DEPTH);
  assign rd        = state_q == PLAY && !stop;
  assign load      = state_q == IDLE && start && cfg_len != '0;
  assign bram_en   = wr_ok || rd;
  assign bram_we   = wr_ok;
  assign bram_addr = rd ? ADDR_W'(cur) : wr_ok ? wr_addr : '0;
  assign bram_din  = wr_ok ? wr_data : '0;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign wr_err    = wr_err_q;
  assign out_valid = vld_q;
  assign out_data  = vld_q ? bram_dout : '0;
  // a stop lands while the previous read's data is on the output, so that sample is the last one
  assign out_last  = lst_q || (vld_q && state_q == PLAY && stop);
  pulse_addr_gen #(.DEPTH(DEPTH), .IDX_W(IDX_W), .RPT_W(RPT_W)) u_addr_gen (
    .clka       (clka),
    .rst_n      (rst_n),
    .load_i     (load),
    .adv_i      (rd),
    .cfg_base_i (cfg_base),
    .cfg_len_i  (cfg_len),
    .cfg_rpt_i  (cfg_rpt),
    .cur_o      (cur),
    .last_o     (last_rd)
  );
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      vld_q    <= 1'b0;
      lst_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      vld_q    <= rd;
      lst_q    <= rd && last_rd;
      done_q   <= state_q == DRAIN;
      wr_err_q <= wr_acc && !wr_ok;
      case (state_q)
        IDLE:    if (load) state_q <= PLAY;
        PLAY:    if (stop || last_rd) state_q <= DRAIN;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pulse_play_ctrl.sv
// tb_pulse_play_ctrl: scoreboard bench for pulse_play_ctrl with a behavioural 1-cycle BRAM
module tb_pulse_play_ctrl;
  logic clka = 1'b0, rst_n = 1'b1;
  logic wr_valid = 1'b0, start = 1'b0, stop = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [12:0] cfg_base = '0, cfg_len = '0;
  logic [15:0] cfg_rpt = '0;
  logic wr_ready, wr_err, busy, done, out_valid, out_last, bram_en, bram_we;
  logic [31:0] out_data, bram_addr, bram_din, bram_dout;
  logic [31:0] mem [0:7999];
  logic [31:0] shadow [0:7999];
  logic [32:0] sb [$];
  logic [31:0] aq [$];
  logic [32:0] e;
  int cyc = 0, first_cyc, last_cyc, n_out;
  int n_vec = 0, n_err = 0;

  pulse_play_ctrl dut (
    .clka(clka), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .start(start), .stop(stop), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .cfg_rpt(cfg_rpt), .busy(busy), .done(done), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  always @(posedge clka)
    if (bram_en) begin
      if (bram_we) mem[bram_addr[12:0]] <= bram_din;
      bram_dout <= mem[bram_addr[12:0]];
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clka) begin
    if (bram_en && !bram_we) begin
      if (aq.size() == 0) chk("extra_read", 1, 0);
      else chk("rd_addr", bram_addr, aq.pop_front());
    end
    if (out_valid) begin
      if (first_cyc < 0) first_cyc = cyc;
      n_out++;
      if (sb.size() == 0) chk("extra_sample", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_data", out_data, e[31:0]);
        chk("out_last", out_last, e[32]);
      end
    end
    if (out_last) begin
      last_cyc = cyc;
      if (!out_valid) chk("last_wo_valid", 1, 0);
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bit ok = a < 8000;
    @(posedge clka); #1;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    #1;
    chk("wr_ready", wr_ready, 1);
    chk("wr_en", bram_en, ok);
    if (ok) begin
      chk("wr_we", bram_we, 1);
      chk("wr_addr", bram_addr, a);
      chk("wr_din", bram_din, d);
      shadow[a[12:0]] = d;
    end
    @(posedge clka); #1;
    wr_valid = 1'b0;
    chk("wr_err", wr_err, !ok);
  endtask

  task automatic push_exp(input int base, input int len, input int nrd);
    int idx;
    for (int i = 0; i < nrd; i++) begin
      idx = (base + i % len) % 8000;
      aq.push_back(idx);
      sb.push_back({i == nrd - 1, shadow[idx]});
    end
  endtask

  task automatic play(input int base, input int len, input int rpt, input int stop_at, input bit hold_wr);
    int nrd = len * (rpt == 0 ? 1 : rpt);
    int sc, dc;
    bit got, early_wr;
    if (stop_at > 0) nrd = stop_at - 1;
    push_exp(base, len, nrd);
    first_cyc = -1; last_cyc = -1; n_out = 0; dc = 0;
    @(posedge clka); #1;
    start = 1'b1; cfg_base = 13'(base); cfg_len = 13'(len); cfg_rpt = 16'(rpt);
    if (hold_wr) begin wr_valid = 1'b1; wr_addr = 32'd20; wr_data = 32'h5555; end
    sc = cyc;
    #1;
    chk("start_wr_ready", wr_ready, 0);
    chk("start_we", bram_we, 0);
    @(posedge clka); #1;
    start = 1'b0;
    if (stop_at > 0) begin
      repeat (stop_at - 1) @(posedge clka);
      #1; stop = 1'b1;
      @(posedge clka); #1; stop = 1'b0;
    end
    got = 0; early_wr = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clka);
      if (wr_valid && wr_ready && !done) early_wr = 1;
      if (done) begin got = 1; dc = cyc; end
    end
    chk("done_seen", got, 1);
    chk("n_samples", n_out, nrd);
    if (stop_at == 0) begin
      chk("latency", first_cyc - sc, 2);
      chk("done_after_last", dc - last_cyc, 1);
    end
    if (hold_wr) begin
      chk("held_wr_early", early_wr, 0);
      chk("held_wr_ready", wr_ready, 1);
      chk("held_wr_we", bram_we, 1);
      chk("held_wr_addr", bram_addr, 20);
      shadow[20] = 32'h5555;
    end
    @(posedge clka); #1;
    wr_valid = 1'b0;
    @(negedge clka);
    chk("sb_empty", sb.size(), 0);
    chk("aq_empty", aq.size(), 0);
    chk("idle_busy", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    for (int i = 0; i < 8000; i++) begin mem[i] = '0; shadow[i] = '0; end
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clka);
    chk("rst_outs", {wr_ready, wr_err, busy, done, out_valid, out_last, bram_en, bram_we}, 0);
    chk("rst_data", {out_data, bram_addr}, 0);
    chk("rst_din", bram_din, 0);
    @(posedge clka); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) wr(i, i + 100);
    wr(7998, 32'hAAAA0001);
    wr(7999, 32'hAAAA0002);
    wr(8000, 32'hDEAD0000);
    wr(32'hFFFF_FFFF, 32'hDEAD0001);
    play(0, 4, 2, 0, 0);
    play(7998, 4, 1, 0, 0);
    play(0, 3, 1, 0, 1);
    play(0, 10, 1, 3, 0);
    play(0, 5, 1, 1, 0);
    play(2, 3, 0, 0, 0);
    play(20, 1, 1, 0, 0);
    @(posedge clka); #1;
    start = 1'b1; cfg_base = '0; cfg_len = '0; cfg_rpt = 16'd1;
    #1 chk("len0_wr_ready", wr_ready, 0);
    @(posedge clka); #1;
    start = 1'b0;
    chk("len0_busy", busy, 0);
    repeat (3) begin @(negedge clka); chk("len0_done", done, 0); end
    push_exp(0, 10, 10);
    first_cyc = -1; n_out = 0;
    @(posedge clka); #1;
    start = 1'b1; cfg_base = '0; cfg_len = 13'd10; cfg_rpt = 16'd1;
    @(posedge clka); #1;
    start = 1'b0;
    repeat (3) @(posedge clka);
    #1 chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_n_out", n_out, 2);
    sb.delete(); aq.delete();
    repeat (2) begin @(negedge clka); chk("rst_no_done", done, 0); end
    @(posedge clka); #1 rst_n = 1'b1;
    repeat (3) begin @(negedge clka); chk("post_rst_done", done, 0); end
    play(0, 10, 1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
